// File: rtl/simd_seq_pkg.sv
// rtl/simd_seq_pkg.sv - shared lane widths, sequencer states and pipe tag for the dual-lane multiplier wrapper
package simd_seq_pkg;

  localparam int A_W = 10;
  localparam int B_W = 9;
  localparam int Z_W = 19;

  typedef enum logic {EMPTY, HALF} seq_state_t;

  typedef struct packed {
    logic lane1_valid;
    logic last0;
    logic last1;
  } pipe_tag_t;

endpackage

// File: rtl/simd_seq_result_fifo.sv
// rtl/simd_seq_result_fifo.sv - result FIFO taking up to two writes and one pop per cycle, head shown combinationally
module simd_seq_result_fifo
  import simd_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       wr0_en,
  input  logic [Z_W:0]               wr0_data,
  input  logic                       wr1_en,
  input  logic [Z_W:0]               wr1_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [Z_W:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [Z_W:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_wr1;

  // Explicit wrap so depths that are not a power of two stay correct
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;
  assign do_pop     = pop && head_valid;
  assign do_wr1     = wr0_en && wr1_en;

  always_ff @(posedge clock_i) begin
    if (wr0_en) mem[wr_ptr] <= wr0_data;
    if (do_wr1) mem[inc(wr_ptr)] <= wr1_data;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr1)      wr_ptr <= inc(inc(wr_ptr));
      else if (wr0_en) wr_ptr <= inc(wr_ptr);
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(wr0_en) + CW'(do_wr1) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/simd_mult_lane_sequencer.sv
// rtl/simd_mult_lane_sequencer.sv - pairs serial operands onto two DSP lanes and re-serializes products in order
// Define SIMD_SEQ_PERF_CNT_EN to add saturating issue/half-issue/stall counters.
module simd_mult_lane_sequencer
  import simd_seq_pkg::*;
#(
  parameter int DSP_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [A_W-1:0] in_a_i,
  input  logic [B_W-1:0] in_b_i,
  input  logic           in_last_i,
  output logic [A_W-1:0] dsp_a0_o,
  output logic [B_W-1:0] dsp_b0_o,
  output logic [A_W-1:0] dsp_a1_o,
  output logic [B_W-1:0] dsp_b1_o,
  input  logic [Z_W-1:0] dsp_z0_i,
  input  logic [Z_W-1:0] dsp_z1_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [Z_W-1:0] out_z_o,
  output logic           out_last_o
`ifdef SIMD_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]    perf_issue_o,
  output logic [31:0]    perf_half_o,
  output logic [31:0]    perf_stall_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  seq_state_t     state;
  logic [A_W-1:0] hold_a;
  logic [B_W-1:0] hold_b;
  logic [CW-1:0]  credits;
  logic [CW-1:0]  fifo_count;
  logic           pipe_vld [DSP_LATENCY+1];
  pipe_tag_t      pipe_tag [DSP_LATENCY+1];
  logic           accept;
  logic           pop;
  logic [1:0]     issue_n;
  logic [Z_W:0]   head;

  // Credits cover FIFO slots plus products still inside the DSP, so a pair issue can never overflow
  assign in_ready_o = (credits >= CW'(2)) && !reset_i;
  assign accept     = in_valid_i && in_ready_o;
  assign pop        = out_valid_o && out_ready_i;

  always_comb begin
    issue_n = 2'd0;
    if (accept) begin
      if (state == HALF)  issue_n = 2'd2;
      else if (in_last_i) issue_n = 2'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state    <= EMPTY;
      hold_a   <= '0;
      hold_b   <= '0;
      dsp_a0_o <= '0;
      dsp_b0_o <= '0;
      dsp_a1_o <= '0;
      dsp_b1_o <= '0;
      credits  <= CW'(FIFO_DEPTH);
      for (int i = 0; i <= DSP_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_tag[i] <= '0;
      end
    end else begin
      credits     <= credits - CW'(issue_n) + CW'(pop);
      pipe_vld[0] <= 1'b0;
      pipe_tag[0] <= '0;
      for (int i = 1; i <= DSP_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      if (accept) begin
        case (state)
          EMPTY: begin
            if (in_last_i) begin
              dsp_a0_o    <= in_a_i;
              dsp_b0_o    <= in_b_i;
              dsp_a1_o    <= '0;
              dsp_b1_o    <= '0;
              pipe_vld[0] <= 1'b1;
              pipe_tag[0] <= '{lane1_valid: 1'b0, last0: 1'b1, last1: 1'b0};
            end else begin
              hold_a <= in_a_i;
              hold_b <= in_b_i;
              state  <= HALF;
            end
          end
          HALF: begin
            dsp_a0_o    <= hold_a;
            dsp_b0_o    <= hold_b;
            dsp_a1_o    <= in_a_i;
            dsp_b1_o    <= in_b_i;
            pipe_vld[0] <= 1'b1;
            pipe_tag[0] <= '{lane1_valid: 1'b1, last0: 1'b0, last1: in_last_i};
            state       <= EMPTY;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  simd_seq_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .wr0_en     (pipe_vld[DSP_LATENCY]),
    .wr0_data   ({pipe_tag[DSP_LATENCY].last0, dsp_z0_i}),
    .wr1_en     (pipe_vld[DSP_LATENCY] && pipe_tag[DSP_LATENCY].lane1_valid),
    .wr1_data   ({pipe_tag[DSP_LATENCY].last1, dsp_z1_i}),
    .pop        (out_ready_i),
    .head_valid (out_valid_o),
    .head_data  (head),
    .count      (fifo_count)
  );

  assign out_last_o = head[Z_W];
  assign out_z_o    = head[Z_W-1:0];

`ifdef SIMD_SEQ_PERF_CNT_EN
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      perf_issue_o <= '0;
      perf_half_o  <= '0;
      perf_stall_o <= '0;
    end else begin
      if (issue_n != 2'd0 && perf_issue_o != '1) perf_issue_o <= perf_issue_o + 32'd1;
      if (issue_n == 2'd1 && perf_half_o != '1)  perf_half_o  <= perf_half_o + 32'd1;
      if (in_valid_i && !in_ready_o && perf_stall_o != '1) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simd_mult_lane_sequencer.sv
// tb/tb_simd_mult_lane_sequencer.sv - randomized bench against an in-order product queue, DSP_LATENCY 1 and 3 instances
module tb_simd_mult_lane_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] in_a = '0;
  logic [8:0] in_b = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic        rdy1, ov1, ol1, rdy3, ov3, ol3;
  logic [9:0]  a0_1, a1_1, a0_3, a1_3;
  logic [8:0]  b0_1, b1_1, b0_3, b1_3;
  logic [18:0] oz1, oz3;
  logic [18:0] z0_1 = '0, z1_1 = '0;
  logic [18:0] p0_3 [3];
  logic [18:0] p1_3 [3];

`ifdef SIMD_SEQ_PERF_CNT_EN
  logic [31:0] pi1, ph1, ps1, pi3, ph3, ps3;
`endif

  simd_mult_lane_sequencer #(.DSP_LATENCY(1), .FIFO_DEPTH(4)) dut1 (
    .clock_i(clk), .reset_i(rst), .in_valid_i(in_valid && !sel), .in_ready_o(rdy1),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
    .dsp_a0_o(a0_1), .dsp_b0_o(b0_1), .dsp_a1_o(a1_1), .dsp_b1_o(b1_1),
    .dsp_z0_i(z0_1), .dsp_z1_i(z1_1),
    .out_valid_o(ov1), .out_ready_i(out_ready), .out_z_o(oz1), .out_last_o(ol1)
`ifdef SIMD_SEQ_PERF_CNT_EN
    , .perf_issue_o(pi1), .perf_half_o(ph1), .perf_stall_o(ps1)
`endif
  );

  simd_mult_lane_sequencer #(.DSP_LATENCY(3), .FIFO_DEPTH(4)) dut3 (
    .clock_i(clk), .reset_i(rst), .in_valid_i(in_valid && sel), .in_ready_o(rdy3),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
    .dsp_a0_o(a0_3), .dsp_b0_o(b0_3), .dsp_a1_o(a1_3), .dsp_b1_o(b1_3),
    .dsp_z0_i(p0_3[2]), .dsp_z1_i(p1_3[2]),
    .out_valid_o(ov3), .out_ready_i(out_ready), .out_z_o(oz3), .out_last_o(ol3)
`ifdef SIMD_SEQ_PERF_CNT_EN
    , .perf_issue_o(pi3), .perf_half_o(ph3), .perf_stall_o(ps3)
`endif
  );

  function automatic logic [18:0] mul(input logic [9:0] a, input logic [8:0] b);
    return {9'b0, a} * {10'b0, b};
  endfunction

  // Stand-in DSPs: products appear DSP_LATENCY cycles after the lane operands
  always @(posedge clk) begin
    z0_1 <= mul(a0_1, b0_1);
    z1_1 <= mul(a1_1, b1_1);
    p0_3[0] <= mul(a0_3, b0_3);
    p1_3[0] <= mul(a1_3, b1_3);
    for (int i = 1; i < 3; i++) begin
      p0_3[i] <= p0_3[i-1];
      p1_3[i] <= p1_3[i-1];
    end
  end

  wire        cur_ready = sel ? rdy3 : rdy1;
  wire        cur_ov    = sel ? ov3 : ov1;
  wire [18:0] cur_oz    = sel ? oz3 : oz1;
  wire        cur_ol    = sel ? ol3 : ol1;
  wire [9:0]  cur_a0    = sel ? a0_3 : a0_1;
  wire [9:0]  cur_a1    = sel ? a1_3 : a1_1;
  wire [31:0] cur_cnt   = sel ? 32'(dut3.fifo_count) : 32'(dut1.fifo_count);
  wire [31:0] cur_cred  = sel ? 32'(dut3.credits) : 32'(dut1.credits);

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: every accepted beat yields exactly one product, in acceptance order
  logic [19:0] exp_q [$];
  logic [19:0] e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (cur_ov && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(cur_oz), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_z", 32'(cur_oz), 32'(e[18:0]));
          check("out_last", 32'(cur_ol), 32'(e[19]));
        end
      end
      if (in_valid && cur_ready) exp_q.push_back({in_last, mul(in_a, in_b)});
      check("fifo_count_bound", 32'(cur_cnt <= 32'd4), 32'd1);
    end
  end

  task automatic send(input logic [9:0] a, input logic [8:0] b, input logic last);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (cur_ready) break;
      if (t > 300) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !cur_ov) break;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic lat_after_lane1(input int exp_lat);
    int lat;
    lat = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      lat++;
      if (cur_ov) break;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  task automatic scenario1(input int exp_lat);
    out_ready = 1'b1;
    send(10'd3, 9'd5, 1'b0);
    send(10'd7, 9'd11, 1'b0);
    lat_after_lane1(exp_lat);
    send(10'd1023, 9'd511, 1'b0);
    send(10'd2, 9'd2, 1'b1);
    drain();
  endtask

  logic       acc;
  logic [9:0] ra;
  logic [8:0] rb;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(rdy1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(rdy1), 32'd1);
    check("post_rst_out_valid", 32'(ov1), 32'd0);
    check("post_rst_out_z", 32'(oz1), 32'd0);
    check("post_rst_out_last", 32'(ol1), 32'd0);
    check("post_rst_dsp_a0", 32'(a0_1), 32'd0);
    check("post_rst_credits", cur_cred, 32'd4);
    @(posedge clk); #1;

    scenario1(3);

    send(10'd6, 9'd7, 1'b1);
    check("odd_dsp_a1", 32'(cur_a1), 32'd0);
    check("odd_dsp_a0", 32'(cur_a0), 32'd6);
    drain();

    send(10'd9, 9'd9, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 19) begin
        check("idle_no_issue_a0", 32'(cur_a0), 32'd6);
        check("idle_no_out", 32'(cur_ov), 32'd0);
      end
    end
    @(posedge clk); #1;
    send(10'd1, 9'd1, 1'b1);
    check("pair_dsp_a0", 32'(cur_a0), 32'd9);
    check("pair_dsp_a1", 32'(cur_a1), 32'd1);
    drain();

    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 10'($urandom); in_b = 9'($urandom); in_last = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = cur_ready;
      @(posedge clk); #1;
      if (acc) begin
        in_a = 10'($urandom); in_b = 9'($urandom); in_last = ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    check("backpressure_in_ready", 32'(cur_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(10'($urandom), 9'($urandom), 1'b1);
    drain();

    for (int i = 0; i < 300; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_a = 10'($urandom); in_b = 9'($urandom); in_last = ($urandom_range(0, 4) == 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = cur_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(10'($urandom), 9'($urandom), 1'b1);
    drain();

    out_ready = 1'b0;
    send(10'd4, 9'd4, 1'b0);
    send(10'd5, 9'd5, 1'b0);
    send(10'd8, 9'd8, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(cur_ov), 32'd0);
    check("midrst_credits", cur_cred, 32'd4);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(10'd2, 9'd3, 1'b1);
    drain();

    sel = 1'b1;
    scenario1(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
